// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the single write port of a sync FIFO.
// A grantee keeps the port until req_last or MAX_BURST words, so packets land contiguously.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req_valid   per-requester word valid
//   req_data    requester i data at [i*WIDTH +: WIDTH]
//   req_last    word is the last of that requester's packet
//   req_ready   word accepted this cycle when valid & ready
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write strobe
//   fifo_din    FIFO write data (data of grant_id)
//   grant_id    current or last grantee index
//   busy        high while a burst is granted
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] rr_ptr, rr_d;
  logic [IW-1:0] grant_d;
  logic [CW-1:0] burst_cnt, cnt_d;
  logic [IW-1:0] pick;
  logic          xfer;
  logic          done;

  // First valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ])
        pick = IW'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

  assign busy       = (state == BURST);
  assign xfer       = busy & req_valid[grant_id] & ~fifo_full;
  assign fifo_wr_en = xfer;
  assign fifo_din   = req_data[int'(grant_id)*WIDTH +: WIDTH];
  assign req_ready  = (busy && !fifo_full)
                    ? (NUM_REQ'(1) << grant_id)
                    : '0;

  // Last and cap on the same word collapse into one exit.
  assign done = xfer & (req_last[grant_id] |
                (burst_cnt == CW'(MAX_BURST - 1)));

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    grant_d = grant_id;
    cnt_d   = burst_cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (done) begin
          cnt_d   = '0;
          rr_d    = grant_id;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = burst_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IW'(NUM_REQ - 1);
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_d;
      grant_id  <= grant_d;
      burst_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle vector table plus
// streaming sequences for burst cap, FIFO full and mid-burst reset.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   rv, rl, rdy;
  logic [NR*W-1:0] rd;
  logic            full, wr, busy;
  logic [W-1:0]    din;
  logic [1:0]      gid;
  logic [W-1:0]    dat [NR];

  int total = 0;
  int bad   = 0;
  int runs[$];
  int gaps[$];

  always #5 clk = ~clk;

  always_comb begin
    rd = '0;
    for (int i = 0; i < NR; i++) rd[i*W +: W] = dat[i];
  end

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_data(rd), .req_last(rl),
    .req_ready(rdy), .fifo_full(full),
    .fifo_wr_en(wr), .fifo_din(din),
    .grant_id(gid), .busy(busy)
  );

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic [3:0] rdy;
    logic       wr;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic [3:0] v, logic [3:0] l, logic f,
    logic [3:0] e_rdy, logic e_wr, logic [1:0] e_gid,
    logic e_busy);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.f = f;
    t.rdy = e_rdy; t.wr = e_wr;
    t.gid = e_gid; t.busy = e_busy;
    return t;
  endfunction

  // Streams n words from requester r; fifo_full is held high for
  // loop cycles f_lo..f_hi (cycle 0 is the arbitration cycle).
  task automatic stream(input string nm, input int r,
                        input int n, input bit use_last,
                        input int f_lo, input int f_hi,
                        input logic [W-1:0] base);
    int sent = 0;
    int run  = 0;
    int gap  = 0;
    int k    = 0;
    runs.delete();
    gaps.delete();
    while ((sent < n || run > 0) && k < 200) begin
      @(negedge clk);
      full  = (k >= f_lo && k <= f_hi);
      rv    = '0;
      rl    = '0;
      rv[r] = (sent < n);
      rl[r] = use_last && (sent == n - 1);
      dat[r] = base + W'(sent);
      #1;
      if (full) begin
        chk({nm, "_full_wr"}, W'(wr), W'(0));
        chk({nm, "_full_rdy"}, W'(rdy), W'(0));
      end
      if (wr) begin
        chk({nm, "_data"}, din, base + W'(sent));
        chk({nm, "_gid"}, W'(gid), W'(r));
        if (sent > 0 && gap > 0) gaps.push_back(gap);
        gap = 0;
        sent++;
        run++;
      end else begin
        if (run > 0) runs.push_back(run);
        run = 0;
        if (sent > 0) gap++;
      end
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got sent=%0d want %0d",
               nm, sent, n);
    end
    chk({nm, "_count"}, W'(sent), W'(n));
    chk({nm, "_idle_after"}, W'(busy), W'(0));
    rv   = '0;
    rl   = '0;
    full = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    rv   = 4'hF;
    rl   = '0;
    full = 1'b0;
    for (int i = 0; i < NR; i++)
      dat[i] = 64'hC0DE_0000_0000_0000 | W'(i);
    repeat (2) @(posedge clk);

    // reset with all valid high
    tbl.push_back(mk(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0));
    // req1 sends 3 words
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 1));
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 1));
    tbl.push_back(mk(0, 4'h2, 4'h2, 0, 4'h2, 1, 1, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0));
    // reset, then round robin 0,1,2,3,0
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h1, 1, 0, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h2, 1, 1, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h4, 1, 2, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 2, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h8, 1, 3, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 3, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h1, 1, 0, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0));
    // grantee drops valid, then a full stall
    tbl.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(0, 4'h5, 4'h1, 1, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h5, 4'h1, 0, 4'h1, 1, 0, 1));
    tbl.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h4, 4'h4, 0, 4'h4, 1, 2, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 2, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst  = tbl[i].r;
      rv   = tbl[i].v;
      rl   = tbl[i].l;
      full = tbl[i].f;
      #1;
      chk($sformatf("v%0d_rdy", i), W'(rdy), W'(tbl[i].rdy));
      chk($sformatf("v%0d_wr", i), W'(wr), W'(tbl[i].wr));
      chk($sformatf("v%0d_gid", i), W'(gid), W'(tbl[i].gid));
      chk($sformatf("v%0d_busy", i), W'(busy),
          W'(tbl[i].busy));
      if (tbl[i].wr)
        chk($sformatf("v%0d_din", i), din, dat[tbl[i].gid]);
    end

    // burst cap: 20 words from req2 -> 8,8,4
    stream("cap", 2, 20, 1'b1, -1, -1, 64'h4000);
    chk("cap_nruns", W'(runs.size()), W'(3));
    if (runs.size() == 3) begin
      chk("cap_run0", W'(runs[0]), W'(8));
      chk("cap_run1", W'(runs[1]), W'(8));
      chk("cap_run2", W'(runs[2]), W'(4));
    end
    chk("cap_ngaps", W'(gaps.size()), W'(2));
    if (gaps.size() == 2) begin
      chk("cap_gap0", W'(gaps[0]), W'(1));
      chk("cap_gap1", W'(gaps[1]), W'(1));
    end

    // full for cycles 3-6 of a capped req0 burst
    stream("full", 0, 8, 1'b0, 3, 6, 64'h5000);
    chk("full_nruns", W'(runs.size()), W'(2));
    if (runs.size() == 2) begin
      chk("full_run0", W'(runs[0]), W'(2));
      chk("full_run1", W'(runs[1]), W'(6));
    end
    chk("full_ngaps", W'(gaps.size()), W'(1));
    if (gaps.size() == 1)
      chk("full_gap0", W'(gaps[0]), W'(4));

    // reset in the middle of a req3 burst
    dat[3] = 64'h6000;
    @(negedge clk);
    rv = 4'h8;
    #1;
    chk("mr_arb_wr", W'(wr), W'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dat[3] = 64'h6000 + W'(i);
      #1;
      chk($sformatf("mr_w%0d_wr", i), W'(wr), W'(1));
      chk($sformatf("mr_w%0d_gid", i), W'(gid), W'(3));
    end
    @(negedge clk);
    rst = 1'b1;
    rv  = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    rv  = 4'h9;
    #1;
    chk("mr_busy", W'(busy), W'(0));
    chk("mr_wr", W'(wr), W'(0));
    chk("mr_gid", W'(gid), W'(0));
    @(negedge clk);
    rl = 4'h9;
    #1;
    chk("mr_g0_gid", W'(gid), W'(0));
    chk("mr_g0_rdy", W'(rdy), W'(1));
    @(negedge clk);
    rv = 4'h8;
    #1;
    chk("mr_idle", W'(busy), W'(0));
    @(negedge clk);
    #1;
    chk("mr_g3_gid", W'(gid), W'(3));
    chk("mr_g3_wr", W'(wr), W'(1));
    @(negedge clk);
    rv = '0;
    rl = '0;
    #1;
    chk("mr_end", W'(busy), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
